// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant types and constants for SRAM and bus arbiters
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  typedef enum logic {GNT_INST, GNT_DATA} gnt_t;
  localparam logic [3:0] SRAM_BE_NONE_N = 4'b1111;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: two-requester round-robin pick, favouring the side not granted last
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  gnt_t last_grant,
  output logic valid,
  output gnt_t gnt
);
  always_comb begin
    valid = inst_req | data_req;
    gnt = (inst_req && data_req) ? ((last_grant == GNT_DATA) ? GNT_INST : GNT_DATA)
                                 : (data_req ? GNT_DATA : GNT_INST);
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: serialises fetch and data accesses onto one SRAM port with wait states
module sram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_ack,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [3:0]        data_be,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);
  state_t     state;
  gnt_t       gnt, last_grant, pick_gnt;
  logic       pick_valid, we_q, wr;
  logic [3:0] wait_cnt;
  arb_rr_pick u_pick (
    .inst_req  (inst_req),
    .data_req  (data_req),
    .last_grant(last_grant),
    .valid     (pick_valid),
    .gnt       (pick_gnt)
  );
  always_comb wr = (pick_gnt == GNT_DATA) && data_we;
  // strobes are registered on entry to ACCESS so no input reaches an output combinationally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      gnt        <= GNT_INST;
      last_grant <= GNT_DATA;
      wait_cnt   <= '0;
      we_q       <= 1'b0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= SRAM_BE_NONE_N;
    end else begin
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      case (state)
        IDLE: if (pick_valid) begin
          gnt        <= pick_gnt;
          last_grant <= pick_gnt;
          we_q       <= wr;
          sram_addr  <= (pick_gnt == GNT_DATA) ? data_addr : inst_addr;
          sram_wdata <= data_wdata;
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= wr;
          sram_we_n  <= !wr;
          sram_be_n  <= wr ? ~data_be : 4'b0000;
          wait_cnt   <= 4'(WAIT_CYCLES);
          state      <= ACCESS;
        end
        ACCESS: if (wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
        else begin
          if (!we_q && gnt == GNT_INST) inst_rdata <= sram_rdata;
          if (!we_q && gnt == GNT_DATA) data_rdata <= sram_rdata;
          inst_ack  <= gnt == GNT_INST;
          data_ack  <= gnt == GNT_DATA;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_be_n <= SRAM_BE_NONE_N;
          state     <= ACK;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of handshake, strobes, round-robin, wait states and reset
module tb_sram_arbiter;
  logic        clk = 1'b0, rst;
  logic        inst_req, data_req, data_we;
  logic [19:0] inst_addr, data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_wdata, sram_rdata;
  logic [31:0] inst_rdata, data_rdata, sram_wdata;
  logic        inst_ack, data_ack, sram_ce_n, sram_oe_n, sram_we_n;
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;
  logic [31:0] z_inst_rdata, z_data_rdata, z_sram_wdata;
  logic        z_inst_ack, z_data_ack, z_sram_ce_n, z_sram_oe_n, z_sram_we_n;
  logic [19:0] z_sram_addr;
  logic [3:0]  z_sram_be_n;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_ack(inst_ack), .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_be(data_be), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );
  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(z_inst_rdata),
    .inst_ack(z_inst_ack), .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_be(data_be), .data_wdata(data_wdata), .data_rdata(z_data_rdata), .data_ack(z_data_ack),
    .sram_addr(z_sram_addr), .sram_wdata(z_sram_wdata), .sram_rdata(sram_rdata), .sram_ce_n(z_sram_ce_n),
    .sram_oe_n(z_sram_oe_n), .sram_we_n(z_sram_we_n), .sram_be_n(z_sram_be_n)
  );

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_we = 0;
    data_addr = 0; data_be = 0; data_wdata = 0; sram_rdata = 0;
    @(negedge clk);
    checks++; if ({inst_ack, data_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b exp 00", {inst_ack, data_ack}); end
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 7'h7f) begin errors++; $display("FAIL reset_strobes got %h exp 7f", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}); end
    checks++; if ({inst_rdata, data_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {inst_rdata, data_rdata}); end
    checks++; if (sram_addr !== 20'h0 || sram_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus got addr %h wdata %h exp 0 0", sram_addr, sram_wdata); end
    checks++; if ({z_sram_ce_n, z_sram_oe_n, z_sram_we_n, z_sram_be_n} !== 7'h7f) begin errors++; $display("FAIL reset_w0_strobes got %h exp 7f", {z_sram_ce_n, z_sram_oe_n, z_sram_we_n, z_sram_be_n}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_inst_read();
    int lat = 0, low = 0, we_low = 0;
    sram_rdata = 32'h2408000A; inst_addr = 20'h00010; inst_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!sram_ce_n && !sram_oe_n && sram_be_n == 4'b0000) low++;
      if (!sram_we_n) we_low++;
      if (inst_ack) begin lat = n; break; end
    end
    inst_req = 1'b0;
    checks++; if (lat != 3) begin errors++; $display("FAIL inst_latency got %0d exp 3", lat); end
    checks++; if (low != 2) begin errors++; $display("FAIL inst_read_strobe_cycles got %0d exp 2", low); end
    checks++; if (we_low != 0) begin errors++; $display("FAIL inst_we_low got %0d exp 0", we_low); end
    checks++; if (inst_rdata !== 32'h2408000A) begin errors++; $display("FAIL inst_rdata got %h exp 2408000a", inst_rdata); end
    checks++; if (sram_addr !== 20'h00010) begin errors++; $display("FAIL inst_addr_hold got %h exp 00010", sram_addr); end
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 7'h7f) begin errors++; $display("FAIL inst_ack_strobes got %h exp 7f", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}); end
    checks++; if (data_ack !== 1'b0 || data_rdata !== 32'h0) begin errors++; $display("FAIL inst_other_side got ack %b rdata %h exp 0 0", data_ack, data_rdata); end
    @(negedge clk);
    checks++; if (inst_ack !== 1'b0) begin errors++; $display("FAIL inst_ack_pulse got %b exp 0", inst_ack); end
  endtask

  task automatic test_data_read();
    int lat = 0;
    sram_rdata = 32'h12345678; data_addr = 20'h00030; data_we = 1'b0; data_be = 4'b0000; data_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (data_ack) begin lat = n; break; end
    end
    data_req = 1'b0;
    checks++; if (lat != 3) begin errors++; $display("FAIL data_read_latency got %0d exp 3", lat); end
    checks++; if (data_rdata !== 32'h12345678) begin errors++; $display("FAIL data_rdata got %h exp 12345678", data_rdata); end
    checks++; if (inst_rdata !== 32'h2408000A) begin errors++; $display("FAIL data_read_inst_rdata got %h exp 2408000a", inst_rdata); end
    @(negedge clk);
  endtask

  task automatic test_data_write();
    int lat = 0, wlow = 0, iack = 0;
    sram_rdata = 32'hFFFFFFFF; data_addr = 20'h00020; data_we = 1'b1; data_be = 4'b0010;
    data_wdata = 32'hDEADBEEF; data_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!sram_ce_n && !sram_we_n && sram_oe_n && sram_be_n == 4'b1101) wlow++;
      if (inst_ack) iack++;
      if (data_ack) begin lat = n; break; end
    end
    data_req = 1'b0; data_we = 1'b0;
    checks++; if (lat != 3) begin errors++; $display("FAIL write_latency got %0d exp 3", lat); end
    checks++; if (wlow != 2) begin errors++; $display("FAIL write_strobe_cycles got %0d exp 2", wlow); end
    checks++; if (data_rdata !== 32'h12345678) begin errors++; $display("FAIL write_rdata_kept got %h exp 12345678", data_rdata); end
    checks++; if (sram_wdata !== 32'hDEADBEEF || sram_addr !== 20'h00020) begin errors++; $display("FAIL write_bus got wdata %h addr %h exp deadbeef 00020", sram_wdata, sram_addr); end
    checks++; if (iack != 0) begin errors++; $display("FAIL write_inst_ack got %0d exp 0", iack); end
    @(negedge clk);
  endtask

  task automatic test_tie();
    int ord[4] = '{9, 9, 9, 9};
    int k = 0, ovl = 0, t[3] = '{0, 0, 0};
    pulse_reset();
    inst_addr = 20'h00040; data_addr = 20'h00050; data_we = 1'b0; sram_rdata = 32'h0000_1111;
    inst_req = 1'b1; data_req = 1'b1;
    for (int n = 0; n < 60 && k < 2; n++) begin
      @(negedge clk);
      if (inst_ack && data_ack) ovl++;
      if (inst_ack) begin ord[k] = 0; k++; inst_req = 1'b0; end
      if (data_ack) begin ord[k] = 1; k++; data_req = 1'b0; end
    end
    @(negedge clk);
    inst_req = 1'b1; data_req = 1'b1;
    for (int n = 0; n < 60 && k < 4; n++) begin
      @(negedge clk);
      if (inst_ack && data_ack) ovl++;
      if (inst_ack) begin ord[k] = 0; k++; inst_req = 1'b0; end
      if (data_ack) begin ord[k] = 1; k++; data_req = 1'b0; end
    end
    checks++; if (ord[0] != 0 || ord[1] != 1) begin errors++; $display("FAIL tie_first_pair got %0d %0d exp 0 1", ord[0], ord[1]); end
    checks++; if (ord[2] != 0 || ord[3] != 1) begin errors++; $display("FAIL tie_second_pair got %0d %0d exp 0 1", ord[2], ord[3]); end
    ord = '{9, 9, 9, 9}; k = 0;
    @(negedge clk);
    inst_req = 1'b1; data_req = 1'b1;
    for (int n = 1; n < 80 && k < 3; n++) begin
      @(negedge clk);
      if (inst_ack && data_ack) ovl++;
      if (inst_ack) begin ord[k] = 0; t[k] = n; k++; end
      if (data_ack) begin ord[k] = 1; t[k] = n; k++; data_req = 1'b0; end
    end
    inst_req = 1'b0;
    checks++; if (ord[0] != 0 || ord[1] != 1 || ord[2] != 0) begin errors++; $display("FAIL rr_alternate got %0d %0d %0d exp 0 1 0", ord[0], ord[1], ord[2]); end
    checks++; if (t[1] - t[0] != 4 || t[2] - t[1] != 4) begin errors++; $display("FAIL rr_spacing got %0d %0d exp 4 4", t[1] - t[0], t[2] - t[1]); end
    checks++; if (ovl != 0) begin errors++; $display("FAIL tie_ack_overlap got %0d exp 0", ovl); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wait0();
    int first = 0, second = 0, low = 0;
    pulse_reset();
    sram_rdata = 32'hA5A5A5A5; inst_addr = 20'h00060; inst_req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (first == 0 && !z_sram_ce_n && !z_sram_oe_n) low++;
      if (z_inst_ack) begin
        if (first == 0) first = n;
        else begin second = n; break; end
      end
    end
    inst_req = 1'b0;
    checks++; if (first != 2) begin errors++; $display("FAIL w0_latency got %0d exp 2", first); end
    checks++; if (low != 1) begin errors++; $display("FAIL w0_access_cycles got %0d exp 1", low); end
    checks++; if (second - first != 3) begin errors++; $display("FAIL w0_spacing got %0d exp 3", second - first); end
    checks++; if (z_inst_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL w0_rdata got %h exp a5a5a5a5", z_inst_rdata); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int dack = 0, lat = 0, wlow = 0;
    pulse_reset();
    data_addr = 20'h00070; data_we = 1'b1; data_be = 4'b1001; data_wdata = 32'h0BADF00D; data_req = 1'b1;
    @(negedge clk);
    checks++; if (sram_we_n !== 1'b0 || sram_ce_n !== 1'b0) begin errors++; $display("FAIL mid_write_active got we_n %b ce_n %b exp 0 0", sram_we_n, sram_ce_n); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 7'h7f || sram_addr !== 20'h0) begin errors++; $display("FAIL mid_write_async got strobes %h addr %h exp 7f 0", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}, sram_addr); end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (data_ack) dack++;
    end
    rst = 1'b0;
    checks++; if (dack != 0) begin errors++; $display("FAIL mid_write_ack got %0d exp 0", dack); end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!sram_ce_n && !sram_we_n && sram_be_n == 4'b0110) wlow++;
      if (data_ack) begin lat = n; break; end
    end
    data_req = 1'b0; data_we = 1'b0;
    checks++; if (lat != 3 || wlow != 2) begin errors++; $display("FAIL reissue_write got lat %0d low %0d exp 3 2", lat, wlow); end
    checks++; if (sram_wdata !== 32'h0BADF00D || sram_addr !== 20'h00070) begin errors++; $display("FAIL reissue_bus got wdata %h addr %h exp 0badf00d 00070", sram_wdata, sram_addr); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_inst_read();
    test_data_read();
    test_data_write();
    test_tie();
    test_wait0();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external SRAM port between the instruction-fetch path (`pc`/`inst_reg`) and the data-memory path (`mem`) of the CPU. Each requester runs a req/ack handshake. The arbiter serialises accesses with round-robin priority and drives the SRAM strobes with a configurable number of wait cycles. The datapath holds (stalls) while its request is outstanding.

## Interface
Parameters:
- `ADDR_W`, 20, SRAM word-address width.
- `WAIT_CYCLES`, 1, extra SRAM access cycles; legal range 0..15.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `inst_req` in 1: fetch request; held high until `inst_ack`.
- `inst_addr` in ADDR_W: fetch word address; held stable while `inst_req` is high.
- `inst_rdata` out 32: fetched word; valid while `inst_ack`=1.
- `inst_ack` out 1: one-cycle completion pulse.
- `data_req` in 1: data request; held high until `data_ack`.
- `data_we` in 1: 1 = write, 0 = read.
- `data_addr` in ADDR_W: data word address.
- `data_be` in 4: active-high byte enables; used for writes only.
- `data_wdata` in 32: write data.
- `data_rdata` out 32: read word; valid while `data_ack`=1.
- `data_ack` out 1: one-cycle completion pulse.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data.
- `sram_ce_n` out 1: chip enable, active-low.
- `sram_oe_n` out 1: output enable, active-low.
- `sram_we_n` out 1: write enable, active-low.
- `sram_be_n` out 4: byte enables, active-low.

## Operation
- FSM has three states: IDLE, ACCESS, ACK.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not in `last_grant`.
  - On a grant: latch addr, we, be, wdata and the grant id into registers; load `wait_cnt` = WAIT_CYCLES; go to ACCESS; update `last_grant`.
- ACCESS:
  - Drive SRAM from the latched registers:
    - `sram_ce_n`=0.
    - Read: `sram_oe_n`=0 and `sram_be_n`=0000.
    - Write: `sram_we_n`=0 and `sram_be_n`=~be.
  - Instruction grants are always reads.
  - If `wait_cnt`≠0, decrement it and stay.
  - If `wait_cnt`=0:
    - Read: capture `sram_rdata` into the granted requester's rdata register.
    - Go to ACK.
- ACK:
  - Assert the granted requester's ack for exactly this cycle.
  - All strobes are deasserted; `sram_addr`/`sram_wdata` still hold the latched values (hold time).
  - Go to IDLE.
- The non-granted requester's rdata and ack are unchanged, and its ack stays 0.
- A write never modifies `data_rdata`.
- Requester rule: drop req (or present a new request) in the cycle after ack. A req still high in IDLE after ack is treated as a new request.
- Data in `*_rdata` holds until that requester's next read completes.
- Reset, including mid-access: FSM→IDLE and `last_grant`=DATA, so instruction fetch wins the first tie. Output reset values:
  - `inst_ack`, `data_ack` = 0.
  - `inst_rdata`, `data_rdata`, `sram_addr`, `sram_wdata` = 0.
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1; `sram_be_n` = 1111.
  - An interrupted write gets no ack; the requester re-issues it after reset.

## Timing
- Latency from req sampled in IDLE to ack high is WAIT_CYCLES+2 cycles: 1 entering ACCESS, WAIT_CYCLES waits, 1 entering ACK.
- ACCESS lasts WAIT_CYCLES+1 cycles.
- Throughput is one access per WAIT_CYCLES+3 cycles, because IDLE sits between accesses.
- `sram_rdata` is sampled at the rising edge that ends the last ACCESS cycle.
- All outputs are registered; there is no combinational path from any input to any output.
- A req that falls while granted is ignored; the access completes and ack still pulses.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum {IDLE, ACCESS, ACK}.
  - Grant enum {GNT_INST, GNT_DATA}.
  - Constant `SRAM_BE_NONE_N`=4'b1111.
- Sub-module `arb_rr_pick` (combinational): inputs `inst_req`, `data_req`, `last_grant`; outputs `valid` and `gnt`. It is reused later for the UART/peripheral bus.
- `wait_cnt` width is 4 bits.

## Test plan
- Reset, then `inst_req` with `inst_addr`=0x00010 and SRAM returning 0x2408000A, WAIT_CYCLES=1:
  - `sram_ce_n`/`sram_oe_n` low for 2 cycles.
  - `inst_ack` pulses 3 cycles after the request with `inst_rdata`=0x2408000A.
- Data write: addr 0x00020, be=0010, wdata 0xDEADBEEF:
  - `sram_we_n` low for 2 cycles with `sram_be_n`=1101.
  - `data_ack` pulses once; `data_rdata` unchanged.
- Both requests raised in the same cycle immediately after reset:
  - Instruction granted first, then data.
  - A second simultaneous pair grants inst again (last=data), then data.
  - Acks never overlap.
- WAIT_CYCLES=0 build: ACCESS lasts 1 cycle; ack arrives 2 cycles after the request; back-to-back requests are spaced 3 cycles.
- `rst` asserted in the middle of a write's ACCESS:
  - All strobes go high and `sram_be_n`=1111 immediately (asynchronously).
  - No `data_ack` is seen.
  - After release, the re-issued write completes normally.
